// File: rtl/mainmem_arb_pkg.sv
// Shared types and default widths for the main-memory arbiter.
package mainmem_arb_pkg;

   localparam int DEF_ADR_W = 16;
   localparam int DEF_DAT_W = 16;

   // Port occupancy: free, or a read is waiting for RAM data
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_BUSY = 1'b1
   } arb_state_e;

   // Which requester owns the in-flight read
   typedef enum logic [1:0] {
      NONE    = 2'd0,
      OWN_IF  = 2'd1,
      OWN_MEM = 2'd2
   } arb_owner_e;

   // A MEM-stage request is any load or store request
   function automatic logic mem_request(input logic rd_req, input logic wr_req);
      return rd_req | wr_req;
   endfunction

   // Loads and stores together are an illegal request combination
   function automatic logic illegal_mem_req(input logic rd_req, input logic wr_req);
      return rd_req & wr_req;
   endfunction

endpackage

// File: rtl/mainmem_arb_grant.sv
// Priority decision between fetch and MEM stage, with a starvation guard
// that forces a fetch grant after STARVE_MAX consecutive MEM grants.
module mainmem_arb_grant
   import mainmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic mem_req,
   input  logic idle,
   output logic grant_if,
   output logic grant_mem
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic [SC_W-1:0] starve_cnt_r;
   logic [SC_W-1:0] starve_cnt_nxt_s;
   logic            starved_s;

   // Winner selection: MEM first unless fetch has been starved too long
   always_comb begin
      starved_s = 1'b0;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      if ((starve_cnt_r == SC_W'(STARVE_MAX)) && if_req) begin
         starved_s = 1'b1;
      end else begin
         starved_s = 1'b0;
      end
      if (idle) begin
         if (mem_req && !starved_s) begin
            grant_mem = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end else begin
            grant_if  = 1'b0;
            grant_mem = 1'b0;
         end
      end else begin
         grant_if  = 1'b0;
         grant_mem = 1'b0;
      end
   end

   // Starve counter update: count MEM wins over a pending fetch, saturating
   always_comb begin
      starve_cnt_nxt_s = starve_cnt_r;
      if (!if_req || grant_if) begin
         starve_cnt_nxt_s = {SC_W{1'b0}};
      end else if (grant_mem && (starve_cnt_r != SC_W'(STARVE_MAX))) begin
         starve_cnt_nxt_s = starve_cnt_r + SC_W'(1);
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end
   end

   // Starve counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= {SC_W{1'b0}};
      end else begin
         starve_cnt_r <= starve_cnt_nxt_s;
      end
   end

endmodule

// File: rtl/mainmem_arbiter.sv
// Main-memory arbiter: shares one synchronous RAM port between instruction
// fetch (reads) and the MEM stage (reads/writes), sequencing the RAM read
// latency and stalling whichever requester cannot be served.
module mainmem_arbiter
   import mainmem_arb_pkg::*;
#(
   parameter int ADR_W      = DEF_ADR_W,
   parameter int DAT_W      = DEF_DAT_W,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [ADR_W-1:0] if_adr,
   output logic [DAT_W-1:0] if_rdata,
   output logic             if_valid,
   output logic             if_waiting,
   input  logic             mem_rd_req,
   input  logic             mem_wr_req,
   input  logic [ADR_W-1:0] main_mem_read_adr,
   input  logic [ADR_W-1:0] main_mem_write_adr,
   input  logic [DAT_W-1:0] main_mem_write_dat,
   output logic [DAT_W-1:0] mem_rdata,
   output logic             mem_valid,
   output logic             main_mem_waiting,
   output logic [ADR_W-1:0] ram_adr,
   output logic [DAT_W-1:0] ram_wdat,
   output logic             ram_we,
   input  logic [DAT_W-1:0] ram_rdata,
   output logic             proto_err
);

   localparam int LAT_W = $clog2(RD_LAT + 1);

   arb_state_e       state_r;
   arb_state_e       state_nxt_s;
   arb_owner_e       owner_r;
   arb_owner_e       owner_nxt_s;
   logic [LAT_W-1:0] lat_cnt_r;
   logic [LAT_W-1:0] lat_cnt_nxt_s;
   logic [ADR_W-1:0] last_adr_r;
   logic [DAT_W-1:0] last_wdat_r;
   logic             proto_err_r;
   logic             mem_req_s;
   logic             idle_s;
   logic             lat_done_s;
   logic             grant_if_s;
   logic             grant_mem_s;

   assign mem_req_s  = mem_request(mem_rd_req, mem_wr_req);
   assign idle_s     = (state_r == IDLE) && !reset;
   assign lat_done_s = (state_r == RD_BUSY) && (lat_cnt_r == LAT_W'(RD_LAT));

   // RAM data goes straight to both readers; valid strobes qualify it
   assign if_rdata  = ram_rdata;
   assign mem_rdata = ram_rdata;
   assign proto_err = proto_err_r;

   mainmem_arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .mem_req   (mem_req_s),
      .idle      (idle_s),
      .grant_if  (grant_if_s),
      .grant_mem (grant_mem_s)
   );

   // FSM next state, RAM port drive and per-port strobes
   always_comb begin
      state_nxt_s      = state_r;
      owner_nxt_s      = owner_r;
      lat_cnt_nxt_s    = lat_cnt_r;
      ram_adr          = last_adr_r;
      ram_wdat         = last_wdat_r;
      ram_we           = 1'b0;
      if_valid         = 1'b0;
      mem_valid        = 1'b0;
      if_waiting       = 1'b0;
      main_mem_waiting = 1'b0;
      if (reset) begin
         state_nxt_s   = IDLE;
         owner_nxt_s   = NONE;
         lat_cnt_nxt_s = {LAT_W{1'b0}};
         ram_adr       = {ADR_W{1'b0}};
         ram_wdat      = {DAT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_mem_s) begin
                  if_waiting = if_req;
                  if (mem_wr_req) begin
                     // Stores finish in the grant cycle; a simultaneous load is dropped
                     ram_adr          = main_mem_write_adr;
                     ram_wdat         = main_mem_write_dat;
                     ram_we           = 1'b1;
                     main_mem_waiting = 1'b0;
                  end else begin
                     ram_adr          = main_mem_read_adr;
                     main_mem_waiting = 1'b1;
                     state_nxt_s      = RD_BUSY;
                     owner_nxt_s      = OWN_MEM;
                     lat_cnt_nxt_s    = LAT_W'(1);
                  end
               end else if (grant_if_s) begin
                  ram_adr          = if_adr;
                  if_waiting       = 1'b1;
                  main_mem_waiting = mem_req_s;
                  state_nxt_s      = RD_BUSY;
                  owner_nxt_s      = OWN_IF;
                  lat_cnt_nxt_s    = LAT_W'(1);
               end else begin
                  if_waiting       = 1'b0;
                  main_mem_waiting = 1'b0;
               end
            end
            RD_BUSY: begin
               if (lat_done_s) begin
                  state_nxt_s   = IDLE;
                  owner_nxt_s   = NONE;
                  lat_cnt_nxt_s = {LAT_W{1'b0}};
               end else begin
                  lat_cnt_nxt_s = lat_cnt_r + LAT_W'(1);
               end
               case (owner_r)
                  OWN_IF: begin
                     if_valid         = lat_done_s;
                     if_waiting       = if_req && !lat_done_s;
                     main_mem_waiting = mem_req_s;
                  end
                  OWN_MEM: begin
                     mem_valid        = lat_done_s;
                     main_mem_waiting = mem_req_s && !lat_done_s;
                     if_waiting       = if_req;
                  end
                  default: begin
                     // No owner while busy cannot happen; free the port
                     state_nxt_s   = IDLE;
                     owner_nxt_s   = NONE;
                     lat_cnt_nxt_s = {LAT_W{1'b0}};
                  end
               endcase
            end
            default: begin
               state_nxt_s   = IDLE;
               owner_nxt_s   = NONE;
               lat_cnt_nxt_s = {LAT_W{1'b0}};
            end
         endcase
      end
   end

   // FSM state, owner, latency counter and held RAM address/data
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         owner_r     <= NONE;
         lat_cnt_r   <= {LAT_W{1'b0}};
         last_adr_r  <= {ADR_W{1'b0}};
         last_wdat_r <= {DAT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         owner_r     <= owner_nxt_s;
         lat_cnt_r   <= lat_cnt_nxt_s;
         last_adr_r  <= ram_adr;
         last_wdat_r <= ram_wdat;
      end
   end

   // Sticky flag for simultaneous load and store requests
   always_ff @(posedge clk) begin
      if (reset) begin
         proto_err_r <= 1'b0;
      end else if (illegal_mem_req(mem_rd_req, mem_wr_req)) begin
         proto_err_r <= 1'b1;
      end else begin
         proto_err_r <= proto_err_r;
      end
   end

endmodule

// File: tb/tb_mainmem_arbiter.sv
// Directed bench for mainmem_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3, each attached to a small synchronous RAM model.
module tb_mainmem_arbiter;

   logic        clk;
   logic        reset;

   // RD_LAT=1 instance signals
   logic        if_req;
   logic [15:0] if_adr;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        if_waiting;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [15:0] rd_adr;
   logic [15:0] wr_adr;
   logic [15:0] wr_dat;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic        mm_waiting;
   logic [15:0] ram_adr;
   logic [15:0] ram_wdat;
   logic        ram_we;
   logic [15:0] ram_rdata;
   logic        proto_err;

   // RD_LAT=3 instance signals
   logic        l3_if_req;
   logic [15:0] l3_if_adr;
   logic [15:0] l3_if_rdata;
   logic        l3_if_valid;
   logic        l3_if_waiting;
   logic [15:0] l3_mem_rdata;
   logic        l3_mem_valid;
   logic        l3_mm_waiting;
   logic [15:0] l3_ram_adr;
   logic [15:0] l3_ram_wdat;
   logic        l3_ram_we;
   logic [15:0] l3_ram_rdata;
   logic        l3_proto_err;
   logic        l3_zero;
   logic [15:0] l3_zero16;

   logic [15:0] mem1 [0:255];
   logic [15:0] mem3 [0:255];
   logic [15:0] l3_d1;
   logic [15:0] l3_d2;

   int n_checks;
   int n_errors;

   mainmem_arbiter #(.ADR_W(16), .DAT_W(16), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .if_req             (if_req),
      .if_adr             (if_adr),
      .if_rdata           (if_rdata),
      .if_valid           (if_valid),
      .if_waiting         (if_waiting),
      .mem_rd_req         (mem_rd_req),
      .mem_wr_req         (mem_wr_req),
      .main_mem_read_adr  (rd_adr),
      .main_mem_write_adr (wr_adr),
      .main_mem_write_dat (wr_dat),
      .mem_rdata          (mem_rdata),
      .mem_valid          (mem_valid),
      .main_mem_waiting   (mm_waiting),
      .ram_adr            (ram_adr),
      .ram_wdat           (ram_wdat),
      .ram_we             (ram_we),
      .ram_rdata          (ram_rdata),
      .proto_err          (proto_err)
   );

   mainmem_arbiter #(.ADR_W(16), .DAT_W(16), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk                (clk),
      .reset              (reset),
      .if_req             (l3_if_req),
      .if_adr             (l3_if_adr),
      .if_rdata           (l3_if_rdata),
      .if_valid           (l3_if_valid),
      .if_waiting         (l3_if_waiting),
      .mem_rd_req         (l3_zero),
      .mem_wr_req         (l3_zero),
      .main_mem_read_adr  (l3_zero16),
      .main_mem_write_adr (l3_zero16),
      .main_mem_write_dat (l3_zero16),
      .mem_rdata          (l3_mem_rdata),
      .mem_valid          (l3_mem_valid),
      .main_mem_waiting   (l3_mm_waiting),
      .ram_adr            (l3_ram_adr),
      .ram_wdat           (l3_ram_wdat),
      .ram_we             (l3_ram_we),
      .ram_rdata          (l3_ram_rdata),
      .proto_err          (l3_proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model with one cycle of read latency
   always @(posedge clk) begin
      if (ram_we) mem1[ram_adr[7:0]] <= ram_wdat;
      ram_rdata <= mem1[ram_adr[7:0]];
   end

   // RAM model with three cycles of read latency
   always @(posedge clk) begin
      if (l3_ram_we) mem3[l3_ram_adr[7:0]] <= l3_ram_wdat;
      l3_d1        <= mem3[l3_ram_adr[7:0]];
      l3_d2        <= l3_d1;
      l3_ram_rdata <= l3_d2;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the middle of the next cycle: inputs change at the falling edge
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b1;
      if_req     = 1'b0;
      if_adr     = 16'h0000;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      rd_adr     = 16'h0000;
      wr_adr     = 16'h0000;
      wr_dat     = 16'h0000;
      l3_if_req  = 1'b0;
      l3_if_adr  = 16'h0000;
      l3_zero    = 1'b0;
      l3_zero16  = 16'h0000;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 16'h0000;
         mem3[i] = 16'h0000;
      end
      mem1[8'h10] = 16'hBEEF;
      mem1[8'h20] = 16'hCAFE;
      mem3[8'h10] = 16'h3C3C;

      // Reset: outputs quiet even with a request present
      next_cycle();
      if_req = 1'b1; if_adr = 16'h1234; mem_wr_req = 1'b1; wr_adr = 16'h5678;
      #1;
      check("rst_ram_adr", ram_adr, 16'h0000);
      check("rst_ram_wdat", ram_wdat, 16'h0000);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_if_waiting", if_waiting, 1'b0);
      check("rst_mm_waiting", mm_waiting, 1'b0);
      check("rst_if_valid", if_valid, 1'b0);
      next_cycle();
      if_req = 1'b0; mem_wr_req = 1'b0;
      #1;
      check("rst_proto_err", proto_err, 1'b0);
      check("rst_mem_valid", mem_valid, 1'b0);

      // Single fetch
      next_cycle();
      reset = 1'b0; if_req = 1'b1; if_adr = 16'h0010;
      #1;
      check("fetch_ram_adr", ram_adr, 16'h0010);
      check("fetch_wait_T", if_waiting, 1'b1);
      check("fetch_valid_T", if_valid, 1'b0);
      next_cycle(); #1;
      check("fetch_valid_T1", if_valid, 1'b1);
      check("fetch_rdata", if_rdata, 16'hBEEF);
      check("fetch_wait_T1", if_waiting, 1'b0);
      next_cycle();
      if_req = 1'b0;
      #1;
      check("fetch_idle_valid", if_valid, 1'b0);
      check("fetch_idle_we", ram_we, 1'b0);
      check("fetch_hold_adr", ram_adr, 16'h0010);

      // Contention: MEM load wins, fetch follows
      next_cycle();
      if_req = 1'b1; if_adr = 16'h0010; mem_rd_req = 1'b1; rd_adr = 16'h0020;
      #1;
      check("cont_ram_adr_T", ram_adr, 16'h0020);
      check("cont_mm_wait_T", mm_waiting, 1'b1);
      check("cont_if_wait_T", if_waiting, 1'b1);
      next_cycle(); #1;
      check("cont_mem_valid", mem_valid, 1'b1);
      check("cont_mem_rdata", mem_rdata, 16'hCAFE);
      check("cont_mm_wait_T1", mm_waiting, 1'b0);
      check("cont_if_wait_T1", if_waiting, 1'b1);
      next_cycle();
      mem_rd_req = 1'b0;
      #1;
      check("cont_ram_adr_T2", ram_adr, 16'h0010);
      check("cont_if_wait_T2", if_waiting, 1'b1);
      check("cont_if_valid_T2", if_valid, 1'b0);
      next_cycle(); #1;
      check("cont_if_valid_T3", if_valid, 1'b1);
      check("cont_if_rdata", if_rdata, 16'hBEEF);
      check("cont_if_wait_T3", if_waiting, 1'b0);
      next_cycle();
      if_req = 1'b0;

      // Starvation: four stores, then fetch is forced in
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if_req = 1'b1; if_adr = 16'h0010;
         mem_wr_req = 1'b1; wr_adr = 16'h0030 + 16'(i); wr_dat = 16'hA000 + 16'(i);
         #1;
         check($sformatf("starve_we_%0d", i), ram_we, 1'b1);
         check($sformatf("starve_adr_%0d", i), ram_adr, 16'h0030 + 16'(i));
         check($sformatf("starve_mmw_%0d", i), mm_waiting, 1'b0);
      end
      next_cycle();
      wr_adr = 16'h0034; wr_dat = 16'hA004;
      #1;
      check("starve_if_grant_we", ram_we, 1'b0);
      check("starve_if_grant_adr", ram_adr, 16'h0010);
      check("starve_5th_stall", mm_waiting, 1'b1);
      check("starve_if_wait", if_waiting, 1'b1);
      next_cycle(); #1;
      check("starve_if_valid", if_valid, 1'b1);
      check("starve_busy_mmw", mm_waiting, 1'b1);
      check("starve_busy_we", ram_we, 1'b0);
      next_cycle(); #1;
      check("starve_5th_we", ram_we, 1'b1);
      check("starve_5th_adr", ram_adr, 16'h0034);
      check("starve_5th_wdat", ram_wdat, 16'hA004);
      check("starve_5th_mmw", mm_waiting, 1'b0);
      next_cycle();
      if_req = 1'b0; mem_wr_req = 1'b0;

      // Store then load of the same word
      next_cycle();
      mem_wr_req = 1'b1; wr_adr = 16'h0040; wr_dat = 16'h1234;
      #1;
      check("sl_we_T", ram_we, 1'b1);
      check("sl_mmw_T", mm_waiting, 1'b0);
      next_cycle();
      mem_wr_req = 1'b0; mem_rd_req = 1'b1; rd_adr = 16'h0040;
      #1;
      check("sl_mmw_T1", mm_waiting, 1'b1);
      check("sl_adr_T1", ram_adr, 16'h0040);
      check("sl_we_T1", ram_we, 1'b0);
      next_cycle(); #1;
      check("sl_mem_valid", mem_valid, 1'b1);
      check("sl_mem_rdata", mem_rdata, 16'h1234);
      check("sl_mmw_T2", mm_waiting, 1'b0);
      next_cycle();
      mem_rd_req = 1'b0;

      // Protocol error: store wins, flag is sticky until reset
      next_cycle();
      mem_rd_req = 1'b1; mem_wr_req = 1'b1; rd_adr = 16'h0020;
      wr_adr = 16'h0050; wr_dat = 16'h5555;
      #1;
      check("perr_we", ram_we, 1'b1);
      check("perr_adr", ram_adr, 16'h0050);
      check("perr_mmw", mm_waiting, 1'b0);
      next_cycle();
      mem_rd_req = 1'b0; mem_wr_req = 1'b0;
      #1;
      check("perr_set", proto_err, 1'b1);
      check("perr_no_read", mem_valid, 1'b0);
      next_cycle();
      if_req = 1'b1; if_adr = 16'h0050;
      #1;
      check("perr_sticky", proto_err, 1'b1);
      check("perr_fetch_adr", ram_adr, 16'h0050);
      next_cycle();
      reset = 1'b1;
      #1;
      check("rstbusy_no_valid", if_valid, 1'b0);
      check("rstbusy_no_wait", if_waiting, 1'b0);
      next_cycle();
      reset = 1'b0;
      #1;
      check("rstbusy_perr_clr", proto_err, 1'b0);
      check("rstbusy_idle_adr", ram_adr, 16'h0050);
      next_cycle(); #1;
      check("rstbusy_valid", if_valid, 1'b1);
      check("rstbusy_rdata", if_rdata, 16'h5555);
      next_cycle();
      if_req = 1'b0;

      // RD_LAT=3 instance: three waiting cycles, valid on the fourth
      next_cycle();
      l3_if_req = 1'b1; l3_if_adr = 16'h0010;
      #1;
      check("l3_adr", l3_ram_adr, 16'h0010);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            next_cycle(); #1;
         end
         check($sformatf("l3_wait_%0d", k), l3_if_waiting, 1'b1);
         check($sformatf("l3_novalid_%0d", k), l3_if_valid, 1'b0);
      end
      next_cycle(); #1;
      check("l3_valid", l3_if_valid, 1'b1);
      check("l3_rdata", l3_if_rdata, 16'h3C3C);
      check("l3_wait_done", l3_if_waiting, 1'b0);
      next_cycle();
      l3_if_req = 1'b0;
      #1;
      check("l3_idle_valid", l3_if_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
